char_stream_buffer: RTL and testbench

//  Parametrised character playback engine: successor to the fixed 8-bit chars_remaining

---
 rtl/char_stream_buffer_if.sv | 22 ++
 rtl/char_stream_buffer.sv | 183 ++++++++++++++++++
 tb/tb_char_stream_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_stream_buffer_if.sv
// Valid/ready write and read channels of the character playback buffer.
// The master side is the host/sink, the slave side is the buffer itself.
interface char_stream_buffer_if #(
   parameter int DATA_W = 8
);
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ready;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/char_stream_buffer.sv
// Character playback engine: load a message through the write channel, then
// stream it once or in a loop through the read channel with a live countdown.
module char_stream_buffer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int LOOP_EN = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   loop_mode,
   input  logic                   abort,
   char_stream_buffer_if.slave    bus,
   output logic [$clog2(DEPTH):0] chars_remaining,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [7:0]             loop_cnt
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic              loop_flag;
   logic              done_q;

   logic full;
   logic idle_en;
   logic play_en;
   logic do_clear;
   logic do_start;
   logic do_abort;
   logic wr_fire;
   logic wr_drop;
   logic rd_fire;
   logic last_xfer;

   // Control decode; clear beats start, and start beats a write in the same cycle.
   assign full      = (fill == CNT_W'(DEPTH));
   assign idle_en   = ena && (state_q == IDLE);
   assign play_en   = ena && (state_q == PLAY);
   assign do_clear  = idle_en && clear;
   assign do_start  = idle_en && !clear && start && (fill != '0);
   assign do_abort  = play_en && abort;
   assign wr_fire   = bus.wr_valid && bus.wr_ready;
   assign wr_drop   = idle_en && !clear && !start && bus.wr_valid && full;
   assign rd_fire   = bus.rd_valid && bus.rd_ready;
   assign last_xfer = rd_fire && (chars_remaining == CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (do_start) begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (do_abort || (last_xfer && !loop_flag)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.wr_ready = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      busy         = 1'b0;
      case (state_q)
         IDLE: begin
            bus.wr_ready = ena && !full && !clear && !start;
         end
         PLAY: begin
            busy         = 1'b1;
            bus.rd_valid = ena;
            if (ena) begin
               bus.rd_data = mem[rd_ptr];
            end
         end
         default: ;
      endcase
   end

   // A done held across an ena=0 stretch is released once ena returns.
   assign done = done_q && ena;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill            <= '0;
         rd_ptr          <= '0;
         chars_remaining <= '0;
         loop_cnt        <= '0;
         loop_flag       <= 1'b0;
         overflow        <= 1'b0;
         done_q          <= 1'b0;
      end else if (ena) begin
         done_q <= last_xfer && !loop_flag && !abort;
         case (state_q)
            IDLE: begin
               if (do_clear) begin
                  fill     <= '0;
                  overflow <= 1'b0;
               end else if (do_start) begin
                  rd_ptr          <= '0;
                  chars_remaining <= fill;
                  loop_cnt        <= '0;
                  loop_flag       <= loop_mode && (LOOP_EN != 0);
               end else begin
                  if (wr_fire) begin
                     fill <= fill + CNT_W'(1);
                  end
                  if (wr_drop) begin
                     overflow <= 1'b1;
                  end
               end
            end
            PLAY: begin
               if (do_abort) begin
                  chars_remaining <= '0;
               end else if (last_xfer) begin
                  if (loop_flag) begin
                     rd_ptr          <= '0;
                     chars_remaining <= fill;
                     if (loop_cnt != 8'hFF) begin
                        loop_cnt <= loop_cnt + 8'd1;
                     end
                  end else begin
                     chars_remaining <= '0;
                  end
               end else if (rd_fire) begin
                  rd_ptr          <= rd_ptr + PTR_W'(1);
                  chars_remaining <= chars_remaining - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the character store has no reset; fill alone says which entries are valid,
   // and leaving it reset-free lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[fill[PTR_W-1:0]] <= bus.wr_data;
      end
   end

   a_fill_bound : assert property (@(posedge clk) disable iff (!rst_n)
      fill <= CNT_W'(DEPTH));

   a_idle_count : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE) |-> (chars_remaining == '0));

   a_rd_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.rd_valid && !bus.rd_ready && !abort) |=> (!bus.rd_valid || $stable(bus.rd_data)));

endmodule

// File: tb/tb_char_stream_buffer.sv
// Directed bench for char_stream_buffer: inputs change on the falling edge,
// outputs are checked 1ns later, and read data is scored against a queue.
module tb_char_stream_buffer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic             clear;
   logic             start;
   logic             loop_mode;
   logic             abort;
   logic [CNT_W-1:0] chars_remaining;
   logic [CNT_W-1:0] fill;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [7:0]       loop_cnt;

   char_stream_buffer_if #(.DATA_W(DATA_W)) bus ();

   char_stream_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LOOP_EN(1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ena            (ena),
      .clear          (clear),
      .start          (start),
      .loop_mode      (loop_mode),
      .abort          (abort),
      .bus            (bus),
      .chars_remaining(chars_remaining),
      .fill           (fill),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow),
      .loop_cnt       (loop_cnt)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  msg[$];
   logic [7:0]  sb[$];
   int          exp_rem;
   int          exp_loop;
   bit          loop_on;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic write_char(input logic [7:0] c);
      bus.wr_valid = 1'b1;
      bus.wr_data  = c;
      #1;
      check("wr_ready", bus.wr_ready, 1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      msg.push_back(c);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      msg.delete();
   endtask

   task automatic start_play(input bit lm);
      start     = 1'b1;
      loop_mode = lm;
      @(negedge clk);
      start     = 1'b0;
      loop_mode = 1'b0;
      loop_on   = lm;
      exp_rem   = msg.size();
      exp_loop  = 0;
      sb.delete();
      foreach (msg[i]) sb.push_back(msg[i]);
   endtask

   // One PLAY cycle: rd_data must match the queue head every cycle, which also
   // proves it is held while the sink stalls.
   task automatic play_cycle(input bit rdy);
      logic [7:0] exp_d;
      bus.rd_ready = rdy;
      #1;
      check("rd_valid", bus.rd_valid, 1);
      check("chars_remaining", chars_remaining, exp_rem);
      check("loop_cnt", loop_cnt, exp_loop);
      check("done_in_play", done, 0);
      check("sb_nonempty", sb.size() != 0, 1);
      exp_d = (sb.size() != 0) ? sb[0] : 8'h00;
      check("rd_data", bus.rd_data, exp_d);
      if (rdy && sb.size() != 0) begin
         void'(sb.pop_front());
         exp_rem--;
         if (exp_rem == 0 && loop_on) begin
            exp_rem = msg.size();
            if (exp_loop < 255) exp_loop++;
            foreach (msg[i]) sb.push_back(msg[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic check_idle_after_done();
      #1;
      check("done_pulse", done, 1);
      check("busy_after", busy, 0);
      check("rem_after", chars_remaining, 0);
      check("rd_valid_after", bus.rd_valid, 0);
      check("rd_data_idle", bus.rd_data, 0);
      check("fill_kept", fill, msg.size());
      @(negedge clk);
      #1;
      check("done_once", done, 0);
      @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      ena          = 1'b0;
      clear        = 1'b0;
      start        = 1'b0;
      loop_mode    = 1'b0;
      abort        = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_fill", fill, 0);
      check("rst_rem", chars_remaining, 0);
      check("rst_loop_cnt", loop_cnt, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_wr_ready", bus.wr_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;

      // One-shot "HI!" at full rate
      write_char("H");
      write_char("I");
      write_char("!");
      #1;
      check("fill_3", fill, 3);
      @(negedge clk);
      bus.rd_ready = 1'b1;
      start_play(1'b0);
      for (int i = 0; i < 3; i++) play_cycle(1'b1);
      check_idle_after_done();

      // Fill to DEPTH, then overflow, then clear
      do_clear();
      for (int i = 0; i < DEPTH; i++) write_char(8'h30 + 8'(i));
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hEE;
      #1;
      check("fill_full", fill, DEPTH);
      check("wr_ready_full", bus.wr_ready, 0);
      check("overflow_before", overflow, 0);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      check("overflow_set", overflow, 1);
      check("fill_still_full", fill, DEPTH);
      @(negedge clk);
      do_clear();
      #1;
      check("fill_cleared", fill, 0);
      check("overflow_cleared", overflow, 0);
      @(negedge clk);

      // Loop mode for 10 transfers, then abort
      write_char("H");
      write_char("I");
      write_char("!");
      start_play(1'b1);
      for (int i = 0; i < 10; i++) play_cycle(1'b1);
      #1;
      check("loop_cnt_3", loop_cnt, 3);
      check("busy_loop", busy, 1);
      @(negedge clk);
      bus.rd_ready = 1'b0;
      abort        = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", busy, 0);
      check("abort_rem", chars_remaining, 0);
      check("abort_done", done, 0);
      check("abort_rd_valid", bus.rd_valid, 0);
      @(negedge clk);

      // Stalls: rd_ready 1,0,0,1 then finish the pass
      start_play(1'b0);
      play_cycle(1'b1);
      play_cycle(1'b0);
      play_cycle(1'b0);
      play_cycle(1'b1);
      play_cycle(1'b1);
      check_idle_after_done();

      // ena low for 4 cycles mid-PLAY
      bus.rd_ready = 1'b1;
      start_play(1'b0);
      play_cycle(1'b1);
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("ena0_rd_valid", bus.rd_valid, 0);
         check("ena0_wr_ready", bus.wr_ready, 0);
         check("ena0_rem", chars_remaining, exp_rem);
         @(negedge clk);
      end
      ena = 1'b1;
      play_cycle(1'b1);
      play_cycle(1'b1);
      check_idle_after_done();

      // start on an empty buffer is ignored
      do_clear();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("empty_start_busy", busy, 0);
      check("empty_start_done", done, 0);
      check("empty_start_rd_valid", bus.rd_valid, 0);
      @(negedge clk);
      #1;
      check("empty_start_done2", done, 0);
      @(negedge clk);

      // Asynchronous reset mid-PLAY
      write_char("H");
      write_char("I");
      write_char("!");
      start_play(1'b1);
      play_cycle(1'b1);
      play_cycle(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rd_valid", bus.rd_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_fill", fill, 0);
      check("arst_rem", chars_remaining, 0);
      check("arst_loop_cnt", loop_cnt, 0);
      check("arst_rd_data", bus.rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
